// File: rtl/handshake_ram.sv
// Byte-addressed data memory for the core's load/store path. Requests arrive as
// level toggles on triggerIn and complete after WAIT_CYCLES wait states.
module handshake_ram #(
  parameter int DATA_W      = 32,
  parameter int DEPTH_BYTES = 4096,
  parameter int ADDR_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clkIn,
  input  logic              rstIn,
  input  logic              triggerIn,
  input  logic              rwIn,
  input  logic [1:0]        sizeIn,
  input  logic [ADDR_W-1:0] addrIn,
  input  logic [DATA_W-1:0] dataIn,
  output logic [DATA_W-1:0] dataOut,
  output logic              readyOut,
  output logic              errOut,
  output logic              overrunOut
);

  localparam int IDX_W = $clog2(DEPTH_BYTES);
  localparam int LANES = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, ERR} stateType;

  stateType state, nextState;

  logic [7:0]        mem [DEPTH_BYTES];
  logic              trigPrev;
  logic              pending;
  logic [3:0]        waitCnt;
  logic              rwReg;
  logic [1:0]        sizeReg;
  logic [IDX_W-1:0]  idxReg;
  logic [DATA_W-1:0] wdataReg;
  logic [DATA_W-1:0] readData;

  logic              toggle;
  logic              accept;
  logic              doAccess;
  logic              doErr;

  logic [3:0]        reqBytes;
  logic [3:0]        regBytes;
  logic [3:0]        alignMask;
  logic [ADDR_W:0]   reqEnd;
  logic              reqErr;

  function automatic logic [3:0] sizeBytes(input logic [1:0] s);
    logic [3:0] n;
    case (s)
      2'b00:   n = 4'd1;
      2'b01:   n = 4'd2;
      2'b10:   n = 4'd4;
      default: n = 4'd8;
    endcase
    return n;
  endfunction

  assign toggle    = triggerIn ^ trigPrev;
  assign reqBytes  = sizeBytes(sizeIn);
  assign regBytes  = sizeBytes(sizeReg);
  assign alignMask = reqBytes - 4'd1;
  // Extra top bit keeps addr+bytes from wrapping near the top of the address space.
  assign reqEnd    = {1'b0, addrIn} + (ADDR_W+1)'(reqBytes);
  assign reqErr    = (|(addrIn[2:0] & alignMask[2:0]))
                   || (reqEnd > (ADDR_W+1)'(DEPTH_BYTES))
                   || ((sizeIn == 2'b11) && (DATA_W == 32));

  always_ff @(posedge clkIn) begin
    if (rstIn) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (toggle || pending) begin
          if (reqErr)                nextState = ERR;
          else if (WAIT_CYCLES == 0) nextState = ACCESS;
          else                       nextState = WAIT;
        end
      end
      WAIT:    if (waitCnt == 4'd1) nextState = ACCESS;
      ACCESS:  nextState = IDLE;
      ERR:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    accept   = (state == IDLE) && (toggle || pending);
    doAccess = (state == ACCESS);
    doErr    = (state == ERR);
  end

  always_comb begin
    readData = '0;
    for (int b = 0; b < LANES; b++) begin
      if (b < int'(regBytes)) readData[8*b +: 8] = mem[idxReg + IDX_W'(b)];
    end
  end

  // A toggle arriving in IDLE while a request is still pending becomes the next pending one.
  always_ff @(posedge clkIn) begin
    trigPrev <= triggerIn;
    if (rstIn) begin
      readyOut   <= 1'b0;
      errOut     <= 1'b0;
      overrunOut <= 1'b0;
      dataOut    <= '0;
      pending    <= 1'b0;
      waitCnt    <= 4'd0;
    end else begin
      if (state == IDLE) begin
        pending <= toggle & pending;
      end else if (toggle) begin
        if (pending) overrunOut <= 1'b1;
        else         pending    <= 1'b1;
      end

      if (accept) begin
        rwReg    <= rwIn;
        sizeReg  <= sizeIn;
        idxReg   <= addrIn[IDX_W-1:0];
        wdataReg <= dataIn;
        readyOut <= 1'b0;
        errOut   <= 1'b0;
        waitCnt  <= 4'(WAIT_CYCLES);
      end else if (state == WAIT) begin
        waitCnt <= waitCnt - 4'd1;
      end

      if (doAccess) begin
        readyOut <= 1'b1;
        if (!rwReg) dataOut <= readData;
      end

      if (doErr) begin
        readyOut <= 1'b1;
        errOut   <= 1'b1;
      end
    end
  end

  // Memory contents survive reset; only the addressed byte lanes are written.
  always_ff @(posedge clkIn) begin
    if (!rstIn && doAccess && rwReg) begin
      for (int b = 0; b < LANES; b++) begin
        if (b < int'(regBytes)) mem[idxReg + IDX_W'(b)] <= wdataReg[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_handshake_ram.sv
// Testbench for handshake_ram: three instances (32-bit/1 wait, 32-bit/3 waits,
// 64-bit/0 waits) driven by a vector table, hand sequences and random traffic.
module tb_handshake_ram;

  localparam int DEPTH = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  trig;
  logic        rwIn;
  logic [1:0]  sizeIn;
  logic [31:0] addrIn;
  logic [63:0] dataIn;
  wire  [31:0] dOut0, dOut1;
  wire  [63:0] dOut2;
  wire  [2:0]  rdy, err, ovr;

  int errors = 0;
  int checks = 0;

  bit [7:0]  mm [3][DEPTH];
  bit [63:0] md [3];

  typedef struct {
    int        inst;
    bit        rw;
    bit [1:0]  size;
    bit [31:0] addr;
    bit [63:0] data;
    bit [63:0] expData;
    bit        expErr;
  } vecT;

  vecT vecs[$];

  handshake_ram #(.DATA_W(32), .DEPTH_BYTES(DEPTH), .ADDR_W(32), .WAIT_CYCLES(1)) u0 (
    .clkIn(clk), .rstIn(rst), .triggerIn(trig[0]), .rwIn(rwIn), .sizeIn(sizeIn),
    .addrIn(addrIn), .dataIn(dataIn[31:0]), .dataOut(dOut0), .readyOut(rdy[0]),
    .errOut(err[0]), .overrunOut(ovr[0]));

  handshake_ram #(.DATA_W(32), .DEPTH_BYTES(DEPTH), .ADDR_W(32), .WAIT_CYCLES(3)) u1 (
    .clkIn(clk), .rstIn(rst), .triggerIn(trig[1]), .rwIn(rwIn), .sizeIn(sizeIn),
    .addrIn(addrIn), .dataIn(dataIn[31:0]), .dataOut(dOut1), .readyOut(rdy[1]),
    .errOut(err[1]), .overrunOut(ovr[1]));

  handshake_ram #(.DATA_W(64), .DEPTH_BYTES(DEPTH), .ADDR_W(32), .WAIT_CYCLES(0)) u2 (
    .clkIn(clk), .rstIn(rst), .triggerIn(trig[2]), .rwIn(rwIn), .sizeIn(sizeIn),
    .addrIn(addrIn), .dataIn(dataIn), .dataOut(dOut2), .readyOut(rdy[2]),
    .errOut(err[2]), .overrunOut(ovr[2]));

  function automatic int waitOf(input int i);
    case (i)
      0:       return 1;
      1:       return 3;
      default: return 0;
    endcase
  endfunction

  function automatic logic [63:0] dataOf(input int i);
    case (i)
      0:       return {32'b0, dOut0};
      1:       return {32'b0, dOut1};
      default: return dOut2;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic addVec(input int inst, input bit rw, input bit [1:0] size, input bit [31:0] addr,
                        input bit [63:0] data, input bit [63:0] expData, input bit expErr);
    vecT v;
    v.inst = inst; v.rw = rw; v.size = size; v.addr = addr;
    v.data = data; v.expData = expData; v.expErr = expErr;
    vecs.push_back(v);
  endtask

  // One toggle request; lat is the number of edges after the accepting edge until ready is seen.
  task automatic applyStimulus(input int inst, input bit rw, input bit [1:0] size, input bit [31:0] addr,
                               input bit [63:0] data, output int lat, output bit gotErr,
                               output bit [63:0] gotData);
    @(negedge clk);
    rwIn = rw; sizeIn = size; addrIn = addr; dataIn = data;
    trig[inst] = ~trig[inst];
    @(posedge clk); #1;
    lat = 0;
    while (!rdy[inst] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    gotErr  = err[inst];
    gotData = dataOf(inst);
  endtask

  task automatic modelApply(input int inst, input bit rw, input bit [1:0] size, input bit [31:0] addr,
                            input bit [63:0] data, output bit expErr, output bit [63:0] expData);
    int bytes;
    longint unsigned a;
    bytes = 1 << size;
    a = addr;
    expErr = (size == 2'd3 && inst != 2) || (a % bytes != 0) || (a + bytes > DEPTH);
    if (!expErr) begin
      if (rw) begin
        for (int i = 0; i < bytes; i++) mm[inst][int'(a) + i] = data[8*i +: 8];
      end else begin
        md[inst] = '0;
        for (int i = 0; i < bytes; i++) md[inst][8*i +: 8] = mm[inst][int'(a) + i];
      end
    end
    expData = md[inst];
  endtask

  task automatic runChecked(input int inst, input bit rw, input bit [1:0] size, input bit [31:0] addr,
                            input bit [63:0] data, input string tag);
    int        lat;
    bit        gErr, eErr;
    bit [63:0] gData, eData;
    applyStimulus(inst, rw, size, addr, data, lat, gErr, gData);
    modelApply(inst, rw, size, addr, data, eErr, eData);
    checkOutput({tag, " err"}, 64'(gErr), 64'(eErr));
    checkOutput({tag, " data"}, gData, eData);
    checkOutput({tag, " latency"}, 64'(lat), 64'(eErr ? 1 : waitOf(inst) + 1));
  endtask

  task automatic checkResetState(input string tag);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("%s ready%0d", tag, i), 64'(rdy[i]), 64'd0);
      checkOutput($sformatf("%s err%0d", tag, i), 64'(err[i]), 64'd0);
      checkOutput($sformatf("%s overrun%0d", tag, i), 64'(ovr[i]), 64'd0);
      checkOutput($sformatf("%s data%0d", tag, i), dataOf(i), 64'd0);
      md[i] = '0;
    end
  endtask

  task automatic countCompletions(input int inst, output int rises, output int firstRun);
    logic prev, cur;
    prev = 1'b0; rises = 0; firstRun = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      cur = rdy[inst];
      if (cur && !prev) rises++;
      if (cur && rises == 1) firstRun++;
      prev = cur;
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int        lat, rises, firstRun;
    bit        gErr, eErr;
    bit [63:0] gData, eData;
    bit        rw;
    bit [1:0]  size;
    bit [31:0] addr;
    int        inst;

    rst = 1'b1; trig = '0; rwIn = 1'b0; sizeIn = '0; addrIn = '0; dataIn = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkResetState("reset");

    addVec(0, 1, 2, 32'h10,  64'hDEADBEEF, 64'h0,        0);
    addVec(0, 0, 2, 32'h10,  64'h0,        64'hDEADBEEF, 0);
    addVec(0, 0, 0, 32'h11,  64'h0,        64'hBE,       0);
    addVec(0, 0, 1, 32'h12,  64'h0,        64'hDEAD,     0);
    addVec(0, 1, 0, 32'h13,  64'h55,       64'hDEAD,     0);
    addVec(0, 0, 2, 32'h10,  64'h0,        64'h55ADBEEF, 0);
    addVec(0, 1, 1, 32'h11,  64'hFFFF,     64'h55ADBEEF, 1);
    addVec(0, 0, 2, 32'h10,  64'h0,        64'h55ADBEEF, 0);
    addVec(0, 0, 2, 32'hFE,  64'h0,        64'h55ADBEEF, 1);
    addVec(0, 0, 0, 32'h10,  64'h0,        64'hEF,       0);
    addVec(0, 0, 3, 32'h10,  64'h0,        64'hEF,       1);
    addVec(0, 1, 2, 32'h20,  64'hCAFEF00D, 64'hEF,       0);
    addVec(0, 0, 2, 32'h20,  64'h0,        64'hCAFEF00D, 0);
    addVec(0, 1, 1, 32'h22,  64'hFFFF9876, 64'hCAFEF00D, 0);
    addVec(0, 0, 2, 32'h20,  64'h0,        64'h9876F00D, 0);
    addVec(0, 1, 0, 32'hFF,  64'hA5,       64'h9876F00D, 0);
    addVec(0, 0, 0, 32'hFF,  64'h0,        64'hA5,       0);
    addVec(0, 0, 2, 32'h100, 64'h0,        64'hA5,       1);
    addVec(2, 1, 3, 32'h08,  64'h0123456789ABCDEF, 64'h0, 0);
    addVec(2, 0, 3, 32'h08,  64'h0,        64'h0123456789ABCDEF, 0);
    addVec(2, 0, 2, 32'h0C,  64'h0,        64'h01234567, 0);
    addVec(2, 0, 3, 32'h0C,  64'h0,        64'h01234567, 1);
    addVec(2, 0, 1, 32'h0A,  64'h0,        64'h89AB,     0);
    addVec(2, 0, 3, 32'h100, 64'h0,        64'h89AB,     1);

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].inst, vecs[k].rw, vecs[k].size, vecs[k].addr, vecs[k].data, lat, gErr, gData);
      modelApply(vecs[k].inst, vecs[k].rw, vecs[k].size, vecs[k].addr, vecs[k].data, eErr, eData);
      checkOutput($sformatf("vec%0d data", k), gData, vecs[k].expData);
      checkOutput($sformatf("vec%0d err", k), 64'(gErr), 64'(vecs[k].expErr));
      checkOutput($sformatf("vec%0d latency", k), 64'(lat),
                  64'(vecs[k].expErr ? 1 : waitOf(vecs[k].inst) + 1));
    end

    // Reset lands while the write to 0x20 is still in its wait state.
    @(negedge clk);
    rwIn = 1'b1; sizeIn = 2'd2; addrIn = 32'h20; dataIn = 64'h12345678;
    trig[0] = ~trig[0];
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checkResetState("midwrite");
    repeat (3) @(negedge clk);
    checkOutput("midwrite no spurious request", 64'(rdy[0]), 64'd0);
    runChecked(0, 0, 2, 32'h20, 64'h0, "midwrite readback");
    checkOutput("midwrite old contents", {32'b0, dOut0}, 64'h9876F00D);

    @(negedge clk); rst = 1'b1; trig[2] = ~trig[2];
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("toggle during reset ignored", 64'(rdy[2]), 64'd0);

    // Queued request: second toggle one cycle after the first.
    @(negedge clk);
    rwIn = 1'b1; sizeIn = 2'd2; addrIn = 32'h40; dataIn = 64'h11223344;
    trig[1] = ~trig[1];
    @(negedge clk);
    rwIn = 1'b0;
    trig[1] = ~trig[1];
    countCompletions(1, rises, firstRun);
    checkOutput("queue completions", 64'(rises), 64'd2);
    checkOutput("queue ready gap", 64'(firstRun), 64'd1);
    checkOutput("queue overrun", 64'(ovr[1]), 64'd0);
    checkOutput("queue err", 64'(err[1]), 64'd0);
    checkOutput("queue read data", {32'b0, dOut1}, 64'h11223344);

    // Three toggles in one busy window: the third is dropped.
    @(negedge clk);
    rwIn = 1'b0; sizeIn = 2'd2; addrIn = 32'h40;
    trig[1] = ~trig[1];
    @(negedge clk); trig[1] = ~trig[1];
    @(negedge clk); trig[1] = ~trig[1];
    countCompletions(1, rises, firstRun);
    checkOutput("overrun completions", 64'(rises), 64'd2);
    checkOutput("overrun flag", 64'(ovr[1]), 64'd1);
    checkOutput("overrun read data", {32'b0, dOut1}, 64'h11223344);

    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checkResetState("reset2");

    for (int a = 0; a < DEPTH; a += 4)
      runChecked(0, 1, 2, 32'(a), {$urandom, $urandom}, $sformatf("fill0 @%0h", a));
    for (int a = 0; a < DEPTH; a += 8)
      runChecked(2, 1, 3, 32'(a), {$urandom, $urandom}, $sformatf("fill2 @%0h", a));

    for (int n = 0; n < 200; n++) begin
      inst = ($urandom_range(0, 1) == 0) ? 0 : 2;
      rw   = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3));
      addr = 32'($urandom_range(0, DEPTH + 7));
      if ($urandom_range(0, 1) == 1) addr = addr & ~(32'(1 << size) - 32'd1);
      runChecked(inst, rw, size, addr, {$urandom, $urandom}, $sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
